// File: rtl/phase_gen.sv
// Machine-cycle timing generator for the RISC control unit: walks N_PHASE one-hot
// beats per machine cycle with stall, single-step, boundary-aligned halt and cycle count.
module phase_gen #(
  parameter int N_PHASE = 4,
  parameter int CW      = (N_PHASE > 2) ? $clog2(N_PHASE) : 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               stall,
  input  logic               step_mode,
  input  logic               step,
  input  logic               halt,
  output logic [N_PHASE-1:0] T,
  output logic [CW-1:0]      phase,
  output logic               cycle_end,
  output logic               running,
  output logic               halted,
  output logic [CNT_W-1:0]   cyc_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2,
    HALTED    = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(N_PHASE - 1);

  state_t state;
  logic   halt_pend;
  logic   at_boundary;

  assign at_boundary = (state == RUN) && (phase == LAST) && !stall;

  // A halt pulse seen mid-cycle is remembered so the cycle always completes before stopping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= '0;
      cyc_cnt   <= '0;
      halt_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          phase     <= '0;
          halt_pend <= 1'b0;
          if (run) state <= RUN;
        end
        RUN: begin
          if (at_boundary) begin
            phase     <= '0;
            cyc_cnt   <= cyc_cnt + CNT_W'(1);
            halt_pend <= 1'b0;
            if (halt || halt_pend) state <= HALTED;
            else if (!run)         state <= IDLE;
            else if (step_mode)    state <= STEP_WAIT;
          end else begin
            halt_pend <= halt_pend | halt;
            if (!stall) phase <= phase + CW'(1);
          end
        end
        STEP_WAIT: begin
          phase     <= '0;
          halt_pend <= 1'b0;
          if (!run)                   state <= IDLE;
          else if (step || !step_mode) state <= RUN;
        end
        HALTED: begin
          phase     <= '0;
          halt_pend <= 1'b0;
          if (!run) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          phase     <= '0;
          halt_pend <= 1'b0;
        end
      endcase
    end
  end

  // Beat decode straight from registered state and phase, so T never lags the phase.
  always_comb begin
    T = '0;
    for (int i = 0; i < N_PHASE; i++) begin
      T[i] = (state == RUN) && (phase == CW'(i));
    end
    cycle_end = at_boundary;
    running   = (state == RUN);
    halted    = (state == HALTED);
  end

endmodule

// File: tb/tb_phase_gen.sv
// Directed bench for phase_gen: vector table for run/stall/halt/step behaviour,
// hand sequences for async reset and a 6-beat instance with counter wrap.
module tb_phase_gen;

  typedef struct {
    logic        run;
    logic        stall;
    logic        stepMode;
    logic        step;
    logic        halt;
    logic [3:0]  expT;
    logic        expCycleEnd;
    logic        expHalted;
    logic [15:0] expCnt;
  } vector_t;

  logic        clk;
  logic        reset;
  logic        run, stall, stepMode, step, halt;
  logic [3:0]  tOut;
  logic [1:0]  phaseOut;
  logic        cycleEnd, runningOut, haltedOut;
  logic [15:0] cycCnt;

  logic        reset6, run6, zero6;
  logic [5:0]  t6;
  logic [2:0]  phase6;
  logic        cycleEnd6, running6, halted6;
  logic [2:0]  cnt6;

  int checks = 0;
  int errors = 0;
  logic invEnable = 1'b0;
  vector_t vecs[$];

  phase_gen #(.N_PHASE(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .step_mode(stepMode),
    .step(step), .halt(halt), .T(tOut), .phase(phaseOut), .cycle_end(cycleEnd),
    .running(runningOut), .halted(haltedOut), .cyc_cnt(cycCnt)
  );

  phase_gen #(.N_PHASE(6), .CNT_W(3)) dut6 (
    .clk(clk), .reset(reset6), .run(run6), .stall(zero6), .step_mode(zero6),
    .step(zero6), .halt(zero6), .T(t6), .phase(phase6), .cycle_end(cycleEnd6),
    .running(running6), .halted(halted6), .cyc_cnt(cnt6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic m, input logic p, input logic h);
    run      = r;
    stall    = s;
    stepMode = m;
    step     = p;
    halt     = h;
  endtask

  task automatic addVec(input logic r, input logic s, input logic m, input logic p, input logic h,
                        input logic [3:0] t, input logic ce, input logic hl, input int cnt);
    vector_t v;
    v.run = r; v.stall = s; v.stepMode = m; v.step = p; v.halt = h;
    v.expT = t; v.expCycleEnd = ce; v.expHalted = hl; v.expCnt = 16'(cnt);
    vecs.push_back(v);
  endtask

  function automatic logic [1:0] phaseOf(input logic [3:0] t);
    case (t)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-hot in RUN, all-zero otherwise, on both instances every clock.
  always @(negedge clk) begin
    if (invEnable) begin
      checkOutput("inv4", {31'b0, (runningOut ? $onehot(tOut) : (tOut == 4'b0))}, 32'd1);
      checkOutput("inv6", {31'b0, (running6 ? $onehot(t6) : (t6 == 6'b0))}, 32'd1);
    end
  end

  initial begin
    reset = 1'b0; reset6 = 1'b0; run6 = 1'b0; zero6 = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);

    // free run: 3 machine cycles, then stall mid-cycle and at the last beat
    addVec(1,0,0,0,0, 4'b0000, 0, 0, 0);
    for (int c = 0; c < 3; c++)
      for (int b = 0; b < 4; b++)
        addVec(1,0,0,0,0, 4'b0001 << b, (b == 3), 0, c);
    addVec(1,0,0,0,0, 4'b0001, 0, 0, 3);
    addVec(1,1,0,0,0, 4'b0010, 0, 0, 3);
    addVec(1,1,0,0,0, 4'b0010, 0, 0, 3);
    addVec(1,1,0,0,0, 4'b0010, 0, 0, 3);
    addVec(1,0,0,0,0, 4'b0010, 0, 0, 3);
    addVec(1,0,0,0,0, 4'b0100, 0, 0, 3);
    addVec(1,1,0,0,0, 4'b1000, 0, 0, 3);
    addVec(1,1,0,0,0, 4'b1000, 0, 0, 3);
    addVec(1,0,0,0,0, 4'b1000, 1, 0, 3);
    addVec(1,0,0,0,0, 4'b0001, 0, 0, 4);
    // halt pulse mid-cycle completes the cycle, then HALTED until run drops
    addVec(1,0,0,0,1, 4'b0010, 0, 0, 4);
    addVec(1,0,0,0,0, 4'b0100, 0, 0, 4);
    addVec(1,0,0,0,0, 4'b1000, 1, 0, 4);
    addVec(1,0,0,0,0, 4'b0000, 0, 1, 5);
    addVec(0,0,0,0,0, 4'b0000, 0, 1, 5);
    addVec(1,0,0,0,0, 4'b0000, 0, 0, 5);
    // single-step: step in RUN ignored, stall ignored in STEP_WAIT
    addVec(1,0,1,0,0, 4'b0001, 0, 0, 5);
    addVec(1,0,1,0,0, 4'b0010, 0, 0, 5);
    addVec(1,0,1,1,0, 4'b0100, 0, 0, 5);
    addVec(1,0,1,0,0, 4'b1000, 1, 0, 5);
    addVec(1,1,1,0,0, 4'b0000, 0, 0, 6);
    addVec(1,0,1,1,0, 4'b0000, 0, 0, 6);
    addVec(1,0,1,0,0, 4'b0001, 0, 0, 6);
    addVec(1,0,1,0,0, 4'b0010, 0, 0, 6);
    addVec(1,0,1,0,0, 4'b0100, 0, 0, 6);
    addVec(1,0,1,0,0, 4'b1000, 1, 0, 6);
    addVec(1,0,1,0,0, 4'b0000, 0, 0, 7);
    addVec(1,0,0,0,0, 4'b0000, 0, 0, 7);
    addVec(1,0,0,0,0, 4'b0001, 0, 0, 7);
    addVec(1,0,0,0,0, 4'b0010, 0, 0, 7);
    addVec(1,0,0,0,0, 4'b0100, 0, 0, 7);
    addVec(1,0,0,0,0, 4'b1000, 1, 0, 7);
    addVec(1,0,0,0,0, 4'b0001, 0, 0, 8);

    tick();
    checkOutput("resetT", {28'b0, tOut}, 32'h0);
    checkOutput("resetPhase", {30'b0, phaseOut}, 32'h0);
    checkOutput("resetCnt", {16'b0, cycCnt}, 32'h0);
    checkOutput("resetFlags", {29'b0, cycleEnd, runningOut, haltedOut}, 32'h0);
    reset = 1'b1; reset6 = 1'b1;
    invEnable = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].run, vecs[i].stall, vecs[i].stepMode, vecs[i].step, vecs[i].halt);
      #1;
      checkOutput($sformatf("v%0d.T", i), {28'b0, tOut}, {28'b0, vecs[i].expT});
      checkOutput($sformatf("v%0d.phase", i), {30'b0, phaseOut}, {30'b0, phaseOf(vecs[i].expT)});
      checkOutput($sformatf("v%0d.flags", i), {29'b0, cycleEnd, runningOut, haltedOut},
                  {29'b0, vecs[i].expCycleEnd, (vecs[i].expT != 4'b0), vecs[i].expHalted});
      checkOutput($sformatf("v%0d.cnt", i), {16'b0, cycCnt}, {16'b0, vecs[i].expCnt});
      tick();
    end

    // asynchronous reset in the middle of T=0100
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("preRstT", {28'b0, tOut}, 32'h2);
    tick();
    checkOutput("preRstT2", {28'b0, tOut}, 32'h4);
    checkOutput("preRstCnt", {16'b0, cycCnt}, 32'd8);
    #2 reset = 1'b0;
    #1;
    checkOutput("asyncT", {28'b0, tOut}, 32'h0);
    checkOutput("asyncPhase", {30'b0, phaseOut}, 32'h0);
    checkOutput("asyncCnt", {16'b0, cycCnt}, 32'h0);
    checkOutput("asyncRunning", {31'b0, runningOut}, 32'h0);
    tick();
    checkOutput("heldT", {28'b0, tOut}, 32'h0);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    tick();
    checkOutput("idleT", {28'b0, tOut}, 32'h0);
    checkOutput("idleCnt", {16'b0, cycCnt}, 32'h0);

    // 6-beat instance with a 3-bit counter that wraps after 8 cycles
    run6 = 1'b1;
    tick();
    for (int c = 1; c <= 54; c++) begin
      int b;
      b = c - 1;
      checkOutput($sformatf("n6.T%0d", c), {26'b0, t6}, 32'(6'b000001 << (b % 6)));
      checkOutput($sformatf("n6.phase%0d", c), {29'b0, phase6}, 32'(b % 6));
      checkOutput($sformatf("n6.ce%0d", c), {31'b0, cycleEnd6}, 32'((b % 6) == 5));
      checkOutput($sformatf("n6.cnt%0d", c), {29'b0, cnt6}, 32'((b / 6) % 8));
      tick();
    end
    checkOutput("n6.finalCnt", {29'b0, cnt6}, 32'd1);
    checkOutput("n6.finalT", {26'b0, t6}, 32'h1);

    invEnable = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
